// File: rtl/vdma_frame_baseaddr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdma_frame_baseaddr_ctrl
// Description : Per-channel frame-buffer base-address generator for the
//               multi-port VDMA. Each channel owns FRAME_NUM frame buffers
//               laid out back to back in DDR. The write side rotates through
//               the buffers as frames complete. The read side picks up the
//               newest completed frame when its own frame starts. With three
//               or more buffers this gives tear-free triple buffering: frames
//               are dropped or repeated, but never read while being written.
// Ports       : axi_aclk       - clock
//               axi_resetn     - asynchronous active-low reset
//               base_addr      - region base address of channel 0
//               ch_enable      - per-channel enable (low forces reset state)
//               wr_frame_done  - per-channel 1-cycle pulse, write frame done
//               rd_frame_start - per-channel 1-cycle pulse, read frame start
//               wr_baseaddr    - packed per-channel write frame base address
//               rd_baseaddr    - packed per-channel read frame base address
//               wr_idx         - packed per-channel write buffer index (3 b)
//               rd_idx         - packed per-channel read buffer index (3 b)
//               frame_drop     - per-channel pulse, ready frame overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module vdma_frame_baseaddr_ctrl #(
    parameter int ASIZE      = 29,
    parameter int CH_NUM     = 8,
    parameter int FRAME_NUM  = 3,
    parameter int FRAME_STEP = 2211840,
    parameter int CH_STEP    = FRAME_STEP * FRAME_NUM
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    input  logic [ASIZE-1:0]        base_addr,
    input  logic [CH_NUM-1:0]       ch_enable,
    input  logic [CH_NUM-1:0]       wr_frame_done,
    input  logic [CH_NUM-1:0]       rd_frame_start,
    output logic [CH_NUM*ASIZE-1:0] wr_baseaddr,
    output logic [CH_NUM*ASIZE-1:0] rd_baseaddr,
    output logic [CH_NUM*3-1:0]     wr_idx,
    output logic [CH_NUM*3-1:0]     rd_idx,
    output logic [CH_NUM-1:0]       frame_drop
);

    // Highest buffer index; the read and ready pointers start here so that
    // the first write buffer (0) is never the one being read.
    localparam logic [2:0]  c_last_ptr   = 3'(FRAME_NUM - 1);
    // With only two buffers the writer cannot avoid the reader, so the
    // collision skip is disabled and tearing is accepted.
    localparam bit          c_skip_en    = (FRAME_NUM >= 3);
    localparam logic [63:0] c_frame_step = 64'(FRAME_STEP);

    // Modulo-FRAME_NUM increment of a buffer pointer.
    function automatic logic [2:0] f_inc(input logic [2:0] p);
        return (p >= c_last_ptr) ? 3'd0 : p + 3'd1;
    endfunction

    generate
        for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
            // Offset of this channel's region from base_addr; widened to
            // 64 bits so the product cannot overflow before truncation.
            localparam logic [63:0] c_ch_off = 64'(n) * 64'(CH_STEP);

            // Pointer state
            logic [2:0]       r_wr_ptr;
            logic [2:0]       r_rd_ptr;
            logic [2:0]       r_rdy_ptr;
            logic             r_rdy_vld;

            // Next-state pointers
            logic [2:0]       w_wr_nxt;
            logic [2:0]       w_rd_nxt;
            logic [2:0]       w_rdy_nxt;
            logic             w_rdy_vld_nxt;
            logic             w_drop;
            logic [2:0]       w_c1;

            // Address datapath
            logic [ASIZE-1:0] w_ch_base;
            logic [ASIZE-1:0] w_wr_addr;
            logic [ASIZE-1:0] w_rd_addr;

            // Registered outputs
            logic [ASIZE-1:0] r_wr_addr;
            logic [ASIZE-1:0] r_rd_addr;
            logic [2:0]       r_wr_idx;
            logic [2:0]       r_rd_idx;
            logic             r_drop;

            always_comb begin
                w_wr_nxt      = r_wr_ptr;
                w_rd_nxt      = r_rd_ptr;
                w_rdy_nxt     = r_rdy_ptr;
                w_rdy_vld_nxt = r_rdy_vld;
                w_drop        = 1'b0;
                w_c1          = f_inc(r_wr_ptr);

                if (!ch_enable[n]) begin
                    // Disabled channel is held in its reset state.
                    w_wr_nxt      = 3'd0;
                    w_rd_nxt      = c_last_ptr;
                    w_rdy_nxt     = c_last_ptr;
                    w_rdy_vld_nxt = 1'b0;
                end else if (wr_frame_done[n] && rd_frame_start[n]) begin
                    // Reader takes the frame that just finished; any older
                    // ready frame is abandoned. Writer moves on by one, which
                    // can never collide because the reader now sits on the
                    // old write buffer.
                    w_rd_nxt      = r_wr_ptr;
                    w_rdy_vld_nxt = 1'b0;
                    w_wr_nxt      = w_c1;
                    w_drop        = r_rdy_vld;
                end else if (wr_frame_done[n]) begin
                    // Publish the finished frame. If a previously published
                    // frame was never picked up, it is lost.
                    w_rdy_nxt     = r_wr_ptr;
                    w_rdy_vld_nxt = 1'b1;
                    w_drop        = r_rdy_vld;
                    // The reader does not move this cycle, so its current
                    // pointer is its next-state pointer.
                    if (c_skip_en && (w_c1 == r_rd_ptr)) begin
                        w_wr_nxt = f_inc(w_c1);
                    end else begin
                        w_wr_nxt = w_c1;
                    end
                end else if (rd_frame_start[n]) begin
                    // No new frame published: keep reading the same buffer
                    // (frame repeat).
                    if (r_rdy_vld) begin
                        w_rd_nxt      = r_rdy_ptr;
                        w_rdy_vld_nxt = 1'b0;
                    end
                end
            end

            assign w_ch_base = base_addr + ASIZE'(c_ch_off);
            assign w_wr_addr = w_ch_base + ASIZE'(64'(w_wr_nxt) * c_frame_step);
            assign w_rd_addr = w_ch_base + ASIZE'(64'(w_rd_nxt) * c_frame_step);

            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_wr_ptr  <= 3'd0;
                    r_rd_ptr  <= c_last_ptr;
                    r_rdy_ptr <= c_last_ptr;
                    r_rdy_vld <= 1'b0;
                end else begin
                    r_wr_ptr  <= w_wr_nxt;
                    r_rd_ptr  <= w_rd_nxt;
                    r_rdy_ptr <= w_rdy_nxt;
                    r_rdy_vld <= w_rdy_vld_nxt;
                end
            end

            // Outputs are loaded from the next-state pointers every cycle,
            // so they follow both strobes and base_addr changes one clock
            // later, and hold zero throughout reset.
            always_ff @(posedge axi_aclk or negedge axi_resetn) begin
                if (!axi_resetn) begin
                    r_wr_addr <= '0;
                    r_rd_addr <= '0;
                    r_wr_idx  <= 3'd0;
                    r_rd_idx  <= 3'd0;
                    r_drop    <= 1'b0;
                end else begin
                    r_wr_addr <= w_wr_addr;
                    r_rd_addr <= w_rd_addr;
                    r_wr_idx  <= w_wr_nxt;
                    r_rd_idx  <= w_rd_nxt;
                    r_drop    <= w_drop;
                end
            end

            assign wr_baseaddr[n*ASIZE +: ASIZE] = r_wr_addr;
            assign rd_baseaddr[n*ASIZE +: ASIZE] = r_rd_addr;
            assign wr_idx[n*3 +: 3]              = r_wr_idx;
            assign rd_idx[n*3 +: 3]              = r_rd_idx;
            assign frame_drop[n]                 = r_drop;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vdma_frame_baseaddr_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vdma_frame_baseaddr_ctrl
// Description : Self-checking bench for vdma_frame_baseaddr_ctrl. Instance A
//               uses 8 channels / 3 buffers, instance B 2 channels / 2
//               buffers. Directed scenarios plus randomized strobes checked
//               against a buffer-rotation reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdma_frame_baseaddr_ctrl;

    localparam int FS = 2211840;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [28:0]   base_addr;

    logic [7:0]    a_en, a_done, a_start;
    logic [231:0]  a_wr_ba, a_rd_ba;
    logic [23:0]   a_wr_idx, a_rd_idx;
    logic [7:0]    a_drop;

    logic [1:0]    b_en, b_done, b_start;
    logic [57:0]   b_wr_ba, b_rd_ba;
    logic [5:0]    b_wr_idx, b_rd_idx;
    logic [1:0]    b_drop;

    int checks = 0;
    int errors = 0;

    // Reference model state: [instance][channel]
    int m_wr [2][8];
    int m_rd [2][8];
    int m_rdy[2][8];
    bit m_vld[2][8];
    bit m_drop[2][8];

    logic [519:0]  ea_all;
    logic [133:0]  eb_all;

    always #5 clk = ~clk;

    vdma_frame_baseaddr_ctrl #(
        .ASIZE(29), .CH_NUM(8), .FRAME_NUM(3), .FRAME_STEP(FS)
    ) dut_a (
        .axi_aclk(clk), .axi_resetn(rst_n), .base_addr(base_addr),
        .ch_enable(a_en), .wr_frame_done(a_done), .rd_frame_start(a_start),
        .wr_baseaddr(a_wr_ba), .rd_baseaddr(a_rd_ba),
        .wr_idx(a_wr_idx), .rd_idx(a_rd_idx), .frame_drop(a_drop)
    );

    vdma_frame_baseaddr_ctrl #(
        .ASIZE(29), .CH_NUM(2), .FRAME_NUM(2), .FRAME_STEP(FS)
    ) dut_b (
        .axi_aclk(clk), .axi_resetn(rst_n), .base_addr(base_addr),
        .ch_enable(b_en), .wr_frame_done(b_done), .rd_frame_start(b_start),
        .wr_baseaddr(b_wr_ba), .rd_baseaddr(b_rd_ba),
        .wr_idx(b_wr_idx), .rd_idx(b_rd_idx), .frame_drop(b_drop)
    );

    wire [519:0] a_all = {a_wr_ba, a_rd_ba, a_wr_idx, a_rd_idx, a_drop};
    wire [133:0] b_all = {b_wr_ba, b_rd_ba, b_wr_idx, b_rd_idx, b_drop};

    function automatic logic [28:0] addr_of(int ch, int fn, int ptr);
        logic [63:0] s;
        s = 64'(base_addr) + 64'(ch * FS * fn) + 64'(ptr * FS);
        return s[28:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int ch = 0; ch < 8; ch++) begin
                m_wr[i][ch]   = 0;
                m_rd[i][ch]   = (i == 0) ? 2 : 1;
                m_rdy[i][ch]  = m_rd[i][ch];
                m_vld[i][ch]  = 1'b0;
                m_drop[i][ch] = 1'b0;
            end
        end
        ea_all = '0;
        eb_all = '0;
    endtask

    // Applies one clock edge of the buffer-rotation rules and recomputes the
    // expected output vectors.
    task automatic model_clock();
        logic [7:0]   en, dn, st;
        logic [231:0] wa, ra;
        logic [23:0]  wi, ri;
        logic [7:0]   dr;
        for (int i = 0; i < 2; i++) begin
            int fn;
            int nch;
            fn  = (i == 0) ? 3 : 2;
            nch = (i == 0) ? 8 : 2;
            en  = (i == 0) ? a_en    : {6'b0, b_en};
            dn  = (i == 0) ? a_done  : {6'b0, b_done};
            st  = (i == 0) ? a_start : {6'b0, b_start};
            for (int ch = 0; ch < nch; ch++) begin
                m_drop[i][ch] = 1'b0;
                if (!en[ch]) begin
                    m_wr[i][ch]  = 0;
                    m_rd[i][ch]  = fn - 1;
                    m_rdy[i][ch] = fn - 1;
                    m_vld[i][ch] = 1'b0;
                end else if (dn[ch] && st[ch]) begin
                    m_drop[i][ch] = m_vld[i][ch];
                    m_rd[i][ch]   = m_wr[i][ch];
                    m_vld[i][ch]  = 1'b0;
                    m_wr[i][ch]   = (m_wr[i][ch] + 1) % fn;
                end else if (dn[ch]) begin
                    int nxt;
                    m_drop[i][ch] = m_vld[i][ch];
                    m_rdy[i][ch]  = m_wr[i][ch];
                    m_vld[i][ch]  = 1'b1;
                    nxt = (m_wr[i][ch] + 1) % fn;
                    if (fn >= 3 && nxt == m_rd[i][ch])
                        nxt = (m_wr[i][ch] + 2) % fn;
                    m_wr[i][ch] = nxt;
                end else if (st[ch] && m_vld[i][ch]) begin
                    m_rd[i][ch]  = m_rdy[i][ch];
                    m_vld[i][ch] = 1'b0;
                end
            end
            wa = '0; ra = '0; wi = '0; ri = '0; dr = '0;
            for (int ch = 0; ch < nch; ch++) begin
                wa[ch*29 +: 29] = addr_of(ch, fn, m_wr[i][ch]);
                ra[ch*29 +: 29] = addr_of(ch, fn, m_rd[i][ch]);
                wi[ch*3 +: 3]   = 3'(m_wr[i][ch]);
                ri[ch*3 +: 3]   = 3'(m_rd[i][ch]);
                dr[ch]          = m_drop[i][ch];
            end
            if (i == 0) ea_all = {wa, ra, wi, ri, dr};
            else        eb_all = {wa[57:0], ra[57:0], wi[5:0], ri[5:0], dr[1:0]};
        end
    endtask

    // Advance one clock; returns 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clear_strobes();
        a_done = '0; a_start = '0; b_done = '0; b_start = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        base_addr = 29'h1000000;
        a_en = 8'hFF; b_en = 2'b11;
        clear_strobes();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (a_all !== '0) begin
            errors++;
            $display("FAIL reset_a: got %h want 0", a_all);
        end
        checks++;
        if (b_all !== '0) begin
            errors++;
            $display("FAIL reset_b: got %h want 0", b_all);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (a_wr_ba[28:0] !== 29'h1000000) begin
            errors++;
            $display("FAIL t1_ch0_wr: got %h want 1000000", a_wr_ba[28:0]);
        end
        checks++;
        if (a_rd_ba[28:0] !== 29'h1438000) begin
            errors++;
            $display("FAIL t1_ch0_rd: got %h want 1438000", a_rd_ba[28:0]);
        end
        checks++;
        if (a_wr_ba[57:29] !== 29'h1654000) begin
            errors++;
            $display("FAIL t1_ch1_wr: got %h want 1654000", a_wr_ba[57:29]);
        end
        checks++;
        if (a_all !== ea_all) begin
            errors++;
            $display("FAIL t1_model_a: got %h want %h", a_all, ea_all);
        end
    endtask

    task automatic test_rotation();
        // T2
        a_done = 8'h01; step(); clear_strobes();
        checks++;
        if (a_wr_idx[2:0] !== 3'd1 || a_wr_ba[28:0] !== 29'h121C000) begin
            errors++;
            $display("FAIL t2_wr: got idx %0d addr %h want 1 121c000", a_wr_idx[2:0], a_wr_ba[28:0]);
        end
        a_start = 8'h01; step(); clear_strobes();
        checks++;
        if (a_rd_idx[2:0] !== 3'd0 || a_rd_ba[28:0] !== 29'h1000000) begin
            errors++;
            $display("FAIL t2_rd: got idx %0d addr %h want 0 1000000", a_rd_idx[2:0], a_rd_ba[28:0]);
        end
        // T3
        a_done = 8'h01; step();
        checks++;
        if (a_wr_idx[2:0] !== 3'd2 || a_drop[0] !== 1'b0) begin
            errors++;
            $display("FAIL t3_first: got idx %0d drop %b want 2 0", a_wr_idx[2:0], a_drop[0]);
        end
        step(); clear_strobes();
        checks++;
        if (a_wr_idx[2:0] !== 3'd1 || a_drop[0] !== 1'b1) begin
            errors++;
            $display("FAIL t3_skip_drop: got idx %0d drop %b want 1 1", a_wr_idx[2:0], a_drop[0]);
        end
        step();
        checks++;
        if (a_drop[0] !== 1'b0) begin
            errors++;
            $display("FAIL t3_drop_pulse: got %b want 0", a_drop[0]);
        end
        // T4
        a_start = 8'h01; step();
        checks++;
        if (a_rd_idx[2:0] !== 3'd2) begin
            errors++;
            $display("FAIL t4_latch: got %0d want 2", a_rd_idx[2:0]);
        end
        step();
        checks++;
        if (a_rd_idx[2:0] !== 3'd2) begin
            errors++;
            $display("FAIL t4_repeat: got %0d want 2", a_rd_idx[2:0]);
        end
        a_done = 8'h01; step(); clear_strobes();
        checks++;
        if (a_rd_idx[2:0] !== 3'd1 || a_wr_idx[2:0] !== 3'd2 || a_rd_ba[28:0] !== 29'h121C000) begin
            errors++;
            $display("FAIL t4_both: got rd %0d wr %0d rdaddr %h want 1 2 121c000",
                     a_rd_idx[2:0], a_wr_idx[2:0], a_rd_ba[28:0]);
        end
        checks++;
        if (a_all !== ea_all) begin
            errors++;
            $display("FAIL t4_model_a: got %h want %h", a_all, ea_all);
        end
    endtask

    task automatic test_two_buffers();
        b_done = 2'b01; step(); clear_strobes();
        checks++;
        if (b_wr_idx[2:0] !== 3'd1) begin
            errors++;
            $display("FAIL t5_wr1: got %0d want 1", b_wr_idx[2:0]);
        end
        b_start = 2'b01; step(); clear_strobes();
        b_done = 2'b01; step(); clear_strobes();
        checks++;
        if (b_wr_idx[2:0] !== 3'd0 || b_rd_idx[2:0] !== 3'd0) begin
            errors++;
            $display("FAIL t5_noskip: got wr %0d rd %0d want 0 0", b_wr_idx[2:0], b_rd_idx[2:0]);
        end
        b_en = 2'b10; b_done = 2'b01; step(); clear_strobes();
        checks++;
        if (b_wr_idx[2:0] !== 3'd0 || b_rd_idx[2:0] !== 3'd1 || b_drop[0] !== 1'b0
            || b_rd_ba[28:0] !== 29'h121C000) begin
            errors++;
            $display("FAIL t5_disable: got wr %0d rd %0d drop %b rdaddr %h want 0 1 0 121c000",
                     b_wr_idx[2:0], b_rd_idx[2:0], b_drop[0], b_rd_ba[28:0]);
        end
        b_en = 2'b11;
        step();
        checks++;
        if (b_all !== eb_all) begin
            errors++;
            $display("FAIL t5_model_b: got %h want %h", b_all, eb_all);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            a_done  = 8'($urandom) & 8'($urandom);
            a_start = 8'($urandom) & 8'($urandom);
            b_done  = 2'($urandom) & 2'($urandom);
            b_start = 2'($urandom) & 2'($urandom);
            a_en = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'hFF;
            b_en = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 49) == 0) base_addr = 29'($urandom);
            step();
            checks++;
            if (a_all !== ea_all) begin
                errors++;
                $display("FAIL rand_a[%0d]: got %h want %h", n, a_all, ea_all);
            end
            checks++;
            if (b_all !== eb_all) begin
                errors++;
                $display("FAIL rand_b[%0d]: got %h want %h", n, b_all, eb_all);
            end
        end
        clear_strobes();
        a_en = 8'hFF; b_en = 2'b11;
    endtask

    task automatic test_async_reset();
        a_done = 8'h55; b_done = 2'b01;
        step();
        #3;
        rst_n = 1'b0;
        #0.5;
        checks++;
        if (a_all !== '0 || b_all !== '0) begin
            errors++;
            $display("FAIL async_reset: got a %h b %h want 0", a_all, b_all);
        end
        model_reset();
        #0.5;
        rst_n = 1'b1;
        clear_strobes();
        base_addr = 29'h1000000;
        step();
        checks++;
        if (a_wr_ba[28:0] !== 29'h1000000 || a_rd_ba[28:0] !== 29'h1438000
            || a_wr_ba[57:29] !== 29'h1654000 || a_drop !== 8'h00) begin
            errors++;
            $display("FAIL t6_post: got wr0 %h rd0 %h wr1 %h drop %h want 1000000 1438000 1654000 00",
                     a_wr_ba[28:0], a_rd_ba[28:0], a_wr_ba[57:29], a_drop);
        end
        checks++;
        if (a_all !== ea_all || b_all !== eb_all) begin
            errors++;
            $display("FAIL t6_model: got a %h b %h want a %h b %h", a_all, b_all, ea_all, eb_all);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_two_buffers();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
